// File: rtl/rf_multiport_sb.sv
// rf_multiport_sb
//   Multi-ported integer register file with an integrated busy scoreboard for a
//   superscalar issue/writeback stage. Register 0 is hardwired to zero.
//   The issue logic sets busy bits through the alloc ports. Accepted writebacks
//   clear them, and flush clears every busy bit.
//
// Ports
//   clk, rst     rising-edge clock, synchronous active-high reset
//   rd_addr      NRD read addresses, port i = [i*ADDR_W +: ADDR_W]
//   rd_data      NRD combinational read data, port i = [i*DATA_W +: DATA_W]
//   rd_busy      busy bit of the register addressed on each read port
//   wr_en/wr_addr/wr_data       NWR write ports (highest index wins on conflict)
//   alloc_en/alloc_addr         NWR busy-set ports
//   flush        clear every busy bit
//   busy_vec     full scoreboard, bit r = register r busy
//
// Configuration
//   RF_BYPASS_EN  when defined, each read port forwards same-cycle write data
//                 and reports the post-edge busy value. When undefined, reads
//                 return the pre-edge contents.

module rf_multiport_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int NRD      = 4,
    parameter int NWR      = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic [NWR-1:0]        alloc_en,
    input  logic [NWR*ADDR_W-1:0] alloc_addr,
    input  logic                  flush,
    output logic [NUM_REGS-1:0]   busy_vec
);

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_nxt;
    logic [NWR-1:0]      wr_ok;
    logic [NWR-1:0]      alloc_ok;

    // Register 0 and indices beyond NUM_REGS are never stored or reported.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (a != '0) && (32'(a) < NUM_REGS);
    endfunction

    always_comb begin
        wr_ok    = '0;
        alloc_ok = '0;
        for (int j = 0; j < NWR; j++) begin
            wr_ok[j]    = wr_en[j]    && addr_ok(wr_addr[j*ADDR_W +: ADDR_W]);
            alloc_ok[j] = alloc_en[j] && addr_ok(alloc_addr[j*ADDR_W +: ADDR_W]);
        end
    end

    // Writeback clears are applied first so that an alloc issued in the same
    // cycle leaves the register busy. Flush overrides both.
    always_comb begin
        busy_nxt = busy_q;
        for (int j = 0; j < NWR; j++)
            if (wr_ok[j])
                busy_nxt[wr_addr[j*ADDR_W +: ADDR_W]] = 1'b0;
        for (int j = 0; j < NWR; j++)
            if (alloc_ok[j])
                busy_nxt[alloc_addr[j*ADDR_W +: ADDR_W]] = 1'b1;
        if (flush)
            busy_nxt = '0;
    end

    // Ascending port order makes the highest-index writer win.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs_q[r] <= '0;
            busy_q <= '0;
        end else begin
            for (int j = 0; j < NWR; j++)
                if (wr_ok[j])
                    regs_q[wr_addr[j*ADDR_W +: ADDR_W]] <= wr_data[j*DATA_W +: DATA_W];
            busy_q <= busy_nxt;
        end
    end

    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            if (addr_ok(rd_addr[i*ADDR_W +: ADDR_W])) begin
                rd_data[i*DATA_W +: DATA_W] = regs_q[rd_addr[i*ADDR_W +: ADDR_W]];
`ifdef RF_BYPASS_EN
                for (int j = 0; j < NWR; j++)
                    if (wr_ok[j] && (wr_addr[j*ADDR_W +: ADDR_W] == rd_addr[i*ADDR_W +: ADDR_W]))
                        rd_data[i*DATA_W +: DATA_W] = wr_data[j*DATA_W +: DATA_W];
                rd_busy[i] = busy_nxt[rd_addr[i*ADDR_W +: ADDR_W]];
`else
                rd_busy[i] = busy_q[rd_addr[i*ADDR_W +: ADDR_W]];
`endif
            end
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: tb/tb_rf_multiport_sb.sv
// Testbench for rf_multiport_sb: directed scenarios plus randomized traffic,
// checked against an array-based reference model of the register file rules.
module tb_rf_multiport_sb;

    localparam int DW = 32, AW = 5, NR = 32, NRD = 4, NWR = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_busy;
    logic [NWR-1:0]    wr_en;
    logic [NWR*AW-1:0] wr_addr;
    logic [NWR*DW-1:0] wr_data;
    logic [NWR-1:0]    alloc_en;
    logic [NWR*AW-1:0] alloc_addr;
    logic              flush;
    logic [NR-1:0]     busy_vec;

    rf_multiport_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NRD(NRD), .NWR(NWR)) dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
        .alloc_addr(alloc_addr), .flush(flush), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] m_regs [NR];
    logic          m_busy [NR];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic valid(input int a);
        return (a != 0) && (a < NR);
    endfunction

    function automatic int wa(input int j); return int'(wr_addr[j*AW +: AW]);    endfunction
    function automatic int aa(input int j); return int'(alloc_addr[j*AW +: AW]); endfunction

    // Busy value a register will hold after this edge, from the priority rules.
    function automatic logic next_busy(input int r);
        if (!valid(r) || flush) return 1'b0;
        for (int j = 0; j < NWR; j++)
            if (alloc_en[j] && aa(j) == r) return 1'b1;
        for (int j = 0; j < NWR; j++)
            if (wr_en[j] && wa(j) == r) return 1'b0;
        return m_busy[r];
    endfunction

    task automatic check_outputs(input string tag);
        logic [DW-1:0] ed;
        logic          eb;
        logic [NR-1:0] ev;
        int            a;
        for (int i = 0; i < NRD; i++) begin
            a  = int'(rd_addr[i*AW +: AW]);
            ed = '0;
            eb = 1'b0;
            if (valid(a)) begin
                ed = m_regs[a];
                eb = m_busy[a];
`ifdef RF_BYPASS_EN
                for (int j = 0; j < NWR; j++)
                    if (wr_en[j] && wa(j) == a) ed = wr_data[j*DW +: DW];
                eb = next_busy(a);
`endif
            end
            chk($sformatf("%s_rd_data%0d", tag, i), 64'(rd_data[i*DW +: DW]), 64'(ed));
            chk($sformatf("%s_rd_busy%0d", tag, i), 64'(rd_busy[i]), 64'(eb));
        end
        for (int r = 0; r < NR; r++) ev[r] = m_busy[r];
        chk($sformatf("%s_busy_vec", tag), 64'(busy_vec), 64'(ev));
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int r = 0; r < NR; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            for (int r = 0; r < NR; r++) m_busy[r] = next_busy(r);
            for (int j = 0; j < NWR; j++)
                if (wr_en[j] && valid(wa(j))) m_regs[wa(j)] = wr_data[j*DW +: DW];
        end
    endtask

    // Called just after a negedge with inputs already driven.
    task automatic cyc(input string tag, input bit do_check = 1'b1);
        #1;
        if (do_check) check_outputs(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 0; flush = 0; wr_en = '0; alloc_en = '0;
        wr_addr = '0; wr_data = '0; alloc_addr = '0;
    endtask

    task automatic set_rd(input int i, input int a);  rd_addr[i*AW +: AW] = AW'(a); endtask
    task automatic set_wr(input int j, input int a, input logic [DW-1:0] d);
        wr_en[j] = 1'b1; wr_addr[j*AW +: AW] = AW'(a); wr_data[j*DW +: DW] = d;
    endtask
    task automatic set_alloc(input int j, input int a);
        alloc_en[j] = 1'b1; alloc_addr[j*AW +: AW] = AW'(a);
    endtask

    initial begin
        rd_addr = '0;
        idle();
        for (int r = 0; r < NR; r++) begin m_regs[r] = '0; m_busy[r] = 1'b0; end
        @(negedge clk);
        rst = 1; cyc("rst0", 0); cyc("rst1", 0);
        idle();

        // 1. reset state
        for (int i = 0; i < NRD; i++) set_rd(i, i);
        #1;
        chk("reset_rd_data", 64'(rd_data[127:64]), 64'd0);
        chk("reset_busy_vec", 64'(busy_vec), 64'd0);
        cyc("reset");

        // 2. single write, write to r0 dropped
        set_wr(0, 5, 32'hDEADBEEF); cyc("wr5");
        idle(); set_rd(0, 5); #1;
        chk("r5_value", 64'(rd_data[31:0]), 64'hDEADBEEF);
        set_wr(0, 0, 32'h12345678); set_rd(1, 0); cyc("wr0");
        idle(); #1;
        chk("r0_zero", 64'(rd_data[63:32]), 64'd0);
        cyc("r0_read");

        // 3. same-address conflict
        set_wr(0, 7, 32'h11); set_wr(1, 7, 32'h22); cyc("conflict");
        idle(); set_rd(2, 7); #1;
        chk("r7_conflict", 64'(rd_data[95:64]), 64'h22);
        cyc("r7_read");

        // 4. alloc vs. writeback
        set_alloc(0, 9); set_rd(3, 9); cyc("alloc9");
        idle(); #1;
        chk("r9_busy", 64'(rd_busy[3]), 64'd1);
        set_wr(0, 9, 32'hA5A5); set_alloc(1, 9); cyc("wr_alloc9");
        idle(); #1;
        chk("r9_still_busy", 64'(rd_busy[3]), 64'd1);
        chk("r9_data", 64'(rd_data[127:96]), 64'hA5A5);
        set_wr(1, 9, 32'hB6B6); cyc("wr9");
        idle(); #1;
        chk("r9_cleared", 64'(rd_busy[3]), 64'd0);
        cyc("r9_read");

        // 5. flush beats alloc, then reset with pending writes
        for (int r = 1; r <= 6; r += 2) begin
            set_alloc(0, r); set_alloc(1, r + 1); cyc("alloc_grp"); idle();
        end
        #1; chk("busy_before_flush", 64'(busy_vec), 64'h7E);
        flush = 1; set_alloc(0, 8); cyc("flush");
        idle(); #1;
        chk("busy_after_flush", 64'(busy_vec), 64'd0);
        set_alloc(0, 4); cyc("alloc4");
        rst = 1; set_wr(0, 12, 32'hCAFE); set_wr(1, 13, 32'hF00D); set_alloc(1, 14);
        cyc("rst_mid", 0);
        idle(); set_rd(0, 5); set_rd(1, 12); #1;
        chk("rst_r5", 64'(rd_data[31:0]), 64'd0);
        chk("rst_busy_vec", 64'(busy_vec), 64'd0);
        cyc("post_rst");

        // 6. same-cycle read of a write
        set_wr(0, 3, 32'h55); set_rd(0, 3); #1;
`ifdef RF_BYPASS_EN
        chk("bypass_r3", 64'(rd_data[31:0]), 64'h55);
`else
        chk("nobypass_r3_old", 64'(rd_data[31:0]), 64'h0);
`endif
        cyc("wr3");
        idle(); #1;
        chk("r3_next", 64'(rd_data[31:0]), 64'h55);
        cyc("r3_read");

        // randomized traffic, concentrated on a few registers for conflicts
        for (int n = 0; n < 400; n++) begin
            int hi;
            hi = (n % 2 == 0) ? 7 : 31;
            rst   = ($urandom_range(0, 99) == 0);
            flush = ($urandom_range(0, 19) == 0);
            for (int i = 0; i < NRD; i++) set_rd(i, $urandom_range(0, hi));
            for (int j = 0; j < NWR; j++) begin
                wr_en[j]    = $urandom_range(0, 1);
                wr_addr[j*AW +: AW]    = AW'($urandom_range(0, hi));
                wr_data[j*DW +: DW]    = $urandom;
                alloc_en[j] = $urandom_range(0, 1);
                alloc_addr[j*AW +: AW] = AW'($urandom_range(0, hi));
            end
            cyc("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
